jtag_uart_sys_cpu_oci_dct_capture: RTL and testbench

JTAG_UART_SYS_CPU_OCI_DCT_CAPTURE -- requirements
Module: jtag_uart_sys_cpu_oci_dct_capture

---
 rtl/jtag_uart_sys_cpu_oci_dct_capture.sv | 131 +++++++++++++
 tb/tb_jtag_uart_sys_cpu_oci_dct_capture.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtag_uart_sys_cpu_oci_dct_capture.sv
// ---------------------------------------------------------------------------
// jtag_uart_sys_cpu_oci_dct_capture
//   Captures debug trace words into a small FIFO while a test runs, then lets
//   the host drain it.  Capture sequence:
//     IDLE --arm--> CAPTURE --test_ending|test_has_ended--> DRAIN
//     DRAIN --(test_has_ended seen && FIFO empty)--> DONE --arm--> CAPTURE
//   Every arm that enters CAPTURE flushes the FIFO and clears the drop
//   statistics on that same edge.
//
// Ports
//   clk, reset_n     rising-edge clock, async active-low reset
//   arm              start / restart capture (ignored in CAPTURE and DRAIN)
//   dct_buffer/count trace word and its count tag; dct_valid qualifies them
//   test_ending      stop accepting new words
//   test_has_ended   test complete; finish once the FIFO is drained
//   rd_req           pop request (honoured in any state when not empty)
//   rd_data          registered popped word {count, buffer}
//   rd_valid         one-cycle pulse, the cycle after a pop
//   level            FIFO occupancy
//   overflow         sticky: a word was dropped on a full FIFO
//   drop_count       saturating count of dropped words
//   state            00 IDLE, 01 CAPTURE, 10 DRAIN, 11 DONE
//   done             state == DONE
// ---------------------------------------------------------------------------
module jtag_uart_sys_cpu_oci_dct_capture #(
  parameter int DATA_W = 30,
  parameter int CNT_W  = 4,
  parameter int DEPTH  = 16,
  parameter int DROP_W = 8
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      arm,
  input  logic [DATA_W-1:0]         dct_buffer,
  input  logic [CNT_W-1:0]          dct_count,
  input  logic                      dct_valid,
  input  logic                      test_ending,
  input  logic                      test_has_ended,
  input  logic                      rd_req,
  output logic [DATA_W+CNT_W-1:0]   rd_data,
  output logic                      rd_valid,
  output logic [$clog2(DEPTH):0]    level,
  output logic                      overflow,
  output logic [DROP_W-1:0]         drop_count,
  output logic [1:0]                state,
  output logic                      done
);
  localparam int AW = $clog2(DEPTH);
  localparam int WW = DATA_W + CNT_W;

  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_CAPT  = 2'b01;
  localparam logic [1:0] S_DRAIN = 2'b10;
  localparam logic [1:0] S_DONE  = 2'b11;

  localparam logic [AW:0]       FULL_LVL = (AW+1)'(DEPTH);
  localparam logic [DROP_W-1:0] DROP_MAX = '1;

  logic [WW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          ended_seen;   // test_has_ended observed since the last arm

  logic          flush, pop, wr_try, wr_ok, drop, ended_now;
  logic [AW:0]   level_nxt;
  logic [1:0]    state_nxt;

  always_comb begin
    flush     = arm && (state == S_IDLE || state == S_DONE);
    // A flush empties the FIFO, so it never pops on the same edge.
    pop       = rd_req && (level != '0) && !flush;
    wr_try    = (state == S_CAPT) && dct_valid;
    // Full FIFO still takes a write when a pop frees a slot on the same edge.
    wr_ok     = wr_try && ((level != FULL_LVL) || pop);
    drop      = wr_try && !wr_ok;
    ended_now = ended_seen || test_has_ended;

    level_nxt = level;
    if (wr_ok && !pop)      level_nxt = level + 1'b1;
    else if (pop && !wr_ok) level_nxt = level - 1'b1;

    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: if (arm) state_nxt = S_CAPT;
      S_CAPT:         if (test_ending || test_has_ended) state_nxt = S_DRAIN;
      default:        if (ended_now && level_nxt == '0) state_nxt = S_DONE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      rd_valid   <= 1'b0;
      rd_data    <= '0;
      overflow   <= 1'b0;
      drop_count <= '0;
      ended_seen <= 1'b0;
    end else begin
      state    <= state_nxt;
      rd_valid <= pop;
      if (pop) rd_data <= mem[rd_ptr];
      if (flush) begin
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        level      <= '0;
        overflow   <= 1'b0;
        drop_count <= '0;
        ended_seen <= 1'b0;
      end else begin
        level <= level_nxt;
        if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
        if (pop)   rd_ptr <= rd_ptr + 1'b1;
        if (drop) begin
          overflow <= 1'b1;
          if (drop_count != DROP_MAX) drop_count <= drop_count + 1'b1;
        end
        if (state == S_CAPT || state == S_DRAIN) ended_seen <= ended_now;
      end
    end
  end

  // Storage needs no reset: occupancy is tracked by level/pointers only.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= {dct_count, dct_buffer};
  end

  assign done = (state == S_DONE);

endmodule

// File: tb/tb_jtag_uart_sys_cpu_oci_dct_capture.sv
// Bench for jtag_uart_sys_cpu_oci_dct_capture: directed scenarios plus a
// random phase, all checked against a queue-based reference model.  A second
// instance with DROP_W=2 shares the stimulus to exercise counter saturation.
module tb_jtag_uart_sys_cpu_oci_dct_capture;
  localparam int DATA_W = 30;
  localparam int CNT_W  = 4;
  localparam int DEPTH  = 16;
  localparam int WW     = DATA_W + CNT_W;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset_n, arm, dct_valid, test_ending, test_has_ended, rd_req;
  logic [DATA_W-1:0] dct_buffer;
  logic [CNT_W-1:0]  dct_count;

  logic [WW-1:0] rd_data, rd_data2;
  logic          rd_valid, rd_valid2, overflow, overflow2, done, done2;
  logic [4:0]    level, level2;
  logic [7:0]    drop_count;
  logic [1:0]    drop_count2;
  logic [1:0]    state, state2;

  jtag_uart_sys_cpu_oci_dct_capture u_dut (
    .clk(clk), .reset_n(reset_n), .arm(arm), .dct_buffer(dct_buffer),
    .dct_count(dct_count), .dct_valid(dct_valid), .test_ending(test_ending),
    .test_has_ended(test_has_ended), .rd_req(rd_req), .rd_data(rd_data),
    .rd_valid(rd_valid), .level(level), .overflow(overflow),
    .drop_count(drop_count), .state(state), .done(done));

  jtag_uart_sys_cpu_oci_dct_capture #(.DROP_W(2)) u_dut2 (
    .clk(clk), .reset_n(reset_n), .arm(arm), .dct_buffer(dct_buffer),
    .dct_count(dct_count), .dct_valid(dct_valid), .test_ending(test_ending),
    .test_has_ended(test_has_ended), .rd_req(rd_req), .rd_data(rd_data2),
    .rd_valid(rd_valid2), .level(level2), .overflow(overflow2),
    .drop_count(drop_count2), .state(state2), .done(done2));

  // ---------------- reference model ----------------
  logic [WW-1:0] mq[$];
  int            m_st, m_drops;
  bit            m_ovf, m_ended, m_rv;
  logic [WW-1:0] m_rd;
  int            total = 0, bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_st = 0; m_drops = 0; m_ovf = 0; m_ended = 0; m_rv = 0; m_rd = '0;
  endtask

  task automatic model_edge();
    bit pop, full;
    if (arm && (m_st == 0 || m_st == 3)) begin
      mq.delete(); m_ovf = 0; m_drops = 0; m_ended = 0; m_st = 1; m_rv = 0;
      return;
    end
    full = (mq.size() == DEPTH);
    pop  = rd_req && (mq.size() != 0);
    if (pop) begin m_rd = mq.pop_front(); m_rv = 1; end
    else m_rv = 0;
    if (m_st == 1 && dct_valid) begin
      if (!full || pop) mq.push_back({dct_count, dct_buffer});
      else begin m_ovf = 1; m_drops++; end
    end
    case (m_st)
      1: begin
        m_ended = m_ended | (test_has_ended === 1'b1);
        if (test_ending || test_has_ended) m_st = 2;
      end
      2: begin
        m_ended = m_ended | (test_has_ended === 1'b1);
        if (m_ended && mq.size() == 0) m_st = 3;
      end
      default: ;
    endcase
  endtask

  task automatic check_all(input string ph);
    chk({ph, ":state"},  state,      m_st);
    chk({ph, ":done"},   done,       m_st == 3);
    chk({ph, ":level"},  level,      mq.size());
    chk({ph, ":ovf"},    overflow,   m_ovf);
    chk({ph, ":drops"},  drop_count, (m_drops > 255) ? 255 : m_drops);
    chk({ph, ":rv"},     rd_valid,   m_rv);
    chk({ph, ":rd"},     rd_data,    m_rd);
    chk({ph, ":state2"}, state2,     m_st);
    chk({ph, ":done2"},  done2,      m_st == 3);
    chk({ph, ":level2"}, level2,     mq.size());
    chk({ph, ":ovf2"},   overflow2,  m_ovf);
    chk({ph, ":drops2"}, drop_count2, (m_drops > 3) ? 3 : m_drops);
    chk({ph, ":rv2"},    rd_valid2,  m_rv);
    chk({ph, ":rd2"},    rd_data2,   m_rd);
  endtask

  task automatic step(input string ph);
    @(posedge clk);
    model_edge();
    #1;
    check_all(ph);
  endtask

  task automatic idle_inputs();
    arm = 0; dct_valid = 0; test_ending = 0; test_has_ended = 0; rd_req = 0;
    dct_buffer = DATA_W'($urandom); dct_count = CNT_W'($urandom);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [WW-1:0] saved[$];
    logic [WW-1:0] newest;
    logic [WW-1:0] w;

    reset_n = 1; idle_inputs(); model_reset();
    #1 reset_n = 0;
    #1 check_all("reset");
    chk("reset_rd_data", rd_data, 0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1;
    rd_req = 1;                       // first edge after release: nothing pops
    step("post_rst");
    rd_req = 0;

    // --- arm, three writes, three pops ---
    arm = 1; step("arm"); arm = 0;
    chk("t1_state", state, 1);
    for (int i = 1; i <= 3; i++) begin
      dct_valid = 1; dct_count = CNT_W'(i); dct_buffer = DATA_W'($urandom);
      step("t1_wr");
    end
    dct_valid = 0;
    chk("t1_lvl3", level, 3);
    for (int i = 1; i <= 3; i++) begin
      rd_req = 1; step("t1_pop");
      chk("t1_rv", rd_valid, 1);
      chk("t1_cnt", rd_data[WW-1 -: CNT_W], i);
      rd_req = 0; step("t1_gap");
      chk("t1_rv_low", rd_valid, 0);
      chk("t1_lvl", level, 3 - i);
    end

    // --- 20 writes without pops: 4 dropped ---
    for (int i = 0; i < 20; i++) begin
      dct_valid = 1; dct_count = CNT_W'(i); dct_buffer = DATA_W'($urandom);
      if (i < DEPTH) saved.push_back({dct_count, dct_buffer});
      step("t2_wr");
    end
    dct_valid = 0;
    chk("t2_lvl16", level, 16);
    chk("t2_ovf", overflow, 1);
    chk("t2_drops4", drop_count, 4);
    chk("t2_drops_sat", drop_count2, 3);
    rd_req = 1;
    for (int i = 0; i < DEPTH; i++) begin
      step("t2_rd");
      chk("t2_rd_word", rd_data, saved[i]);
    end
    rd_req = 0; step("t2_end");
    chk("t2_empty", level, 0);
    saved.delete();

    // --- full FIFO, simultaneous write and pop ---
    for (int i = 0; i < DEPTH; i++) begin
      dct_valid = 1; dct_count = CNT_W'(i); dct_buffer = DATA_W'($urandom);
      saved.push_back({dct_count, dct_buffer});
      step("t3_fill");
    end
    dct_count = 4'hA; dct_buffer = DATA_W'($urandom); rd_req = 1;
    newest = {dct_count, dct_buffer};
    step("t3_wrpop");
    dct_valid = 0;
    chk("t3_lvl16", level, 16);
    chk("t3_no_drop", drop_count, 4);
    chk("t3_first", rd_data, saved[0]);
    for (int i = 1; i <= DEPTH; i++) begin
      step("t3_rd");
      if (i == DEPTH) chk("t3_new_16th", rd_data, newest);
    end
    rd_req = 0; step("t3_end");

    // --- arm ignored in CAPTURE; six more drops ---
    arm = 1; dct_valid = 1; dct_buffer = DATA_W'($urandom);
    step("t4_arm_cap");
    arm = 0;
    chk("t4_no_flush", level, 1);
    chk("t4_state", state, 1);
    for (int i = 0; i < DEPTH - 1 + 6; i++) begin
      dct_buffer = DATA_W'($urandom); dct_count = CNT_W'(i);
      step("t4_wr");
    end
    dct_valid = 0;
    chk("t4_drops10", drop_count, 10);
    chk("t4_sat3", drop_count2, 3);

    // --- drain to DONE ---
    rd_req = 1;
    repeat (12) step("t5_pop");
    rd_req = 0;
    chk("t5_lvl4", level, 4);
    test_ending = 1; dct_valid = 1; dct_buffer = DATA_W'($urandom);
    step("t5_ending");
    test_ending = 0;
    chk("t5_drain", state, 2);
    chk("t5_lvl5", level, 5);
    dct_buffer = DATA_W'($urandom);
    step("t5_drain_wr");
    dct_valid = 0;
    chk("t5_drain_nowr", level, 5);
    chk("t5_drain_nodrop", drop_count, 10);
    test_has_ended = 1; step("t5_ended"); test_has_ended = 0;
    chk("t5_still_drain", state, 2);
    rd_req = 1;
    for (int i = 1; i <= 5; i++) begin
      step("t5_pop2");
      chk("t5_done", done, i == 5);
    end
    rd_req = 0;
    arm = 1; step("t5_rearm"); arm = 0;
    chk("t5_re_lvl", level, 0);
    chk("t5_re_ovf", overflow, 0);
    chk("t5_re_drop", drop_count, 0);
    chk("t5_re_drop2", drop_count2, 0);
    chk("t5_re_state", state, 1);

    // --- random phase ---
    for (int c = 0; c < 500; c++) begin
      arm            = ($urandom_range(0, 15) == 0);
      dct_valid      = ($urandom_range(0, 9) < 7);
      rd_req         = ($urandom_range(0, 9) < 4);
      test_ending    = ($urandom_range(0, 59) == 0);
      test_has_ended = ($urandom_range(0, 79) == 0);
      dct_buffer     = DATA_W'($urandom);
      dct_count      = CNT_W'($urandom);
      step("rand");
    end
    idle_inputs();

    // --- mid-CAPTURE reset with level 7 ---
    reset_n = 0; model_reset();
    #1 check_all("rst2");
    @(posedge clk);
    #1 reset_n = 1;
    step("rst2_rel");
    arm = 1; step("t6_arm"); arm = 0;
    dct_valid = 1;
    repeat (7) begin dct_buffer = DATA_W'($urandom); step("t6_wr"); end
    dct_valid = 0;
    chk("t6_lvl7", level, 7);
    #3 reset_n = 0; model_reset();
    #1;
    chk("t6_rst_lvl", level, 0);
    chk("t6_rst_state", state, 0);
    chk("t6_rst_rv", rd_valid, 0);
    chk("t6_rst_rd", rd_data, 0);
    chk("t6_rst_done", done, 0);
    check_all("t6_rst");
    @(posedge clk);
    #1 reset_n = 1;
    step("t6_rel");
    arm = 1; step("t6_rearm"); arm = 0;
    chk("t6_empty", level, 0);
    dct_valid = 1; dct_count = 4'h5; dct_buffer = DATA_W'($urandom);
    w = {dct_count, dct_buffer};
    step("t6_wr1");
    dct_valid = 0; rd_req = 1;
    step("t6_pop1");
    rd_req = 0;
    chk("t6_first_word", rd_data, w);
    step("t6_end");
    chk("t6_lvl0", level, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
